// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side stream engine.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_DEPTH      = 64;
  localparam int RD_BUF_DEPTH    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } rd_state_t;

  // Circular pointer advance for the 3-entry read buffer (2 -> 0).
  function automatic logic [1:0] rd_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : (ptr + 2'd1);
  endfunction

endpackage

// File: rtl/rd_skid_buf3.sv
// Three-entry circular buffer absorbing the FIFO's registered read latency.
// Clear has priority over push/pop; push into a full buffer and pop from an empty one are ignored.
module rd_skid_buf3
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop_ok_s, push_ok_s;

  assign pop_ok_s  = pop_i && (occ_q != 2'd0);
  assign push_ok_s = push_i && ((occ_q != 2'(RD_BUF_DEPTH)) || pop_ok_s);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      occ_d    = 2'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = rd_ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_ok_s && !clear_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO onto a valid/ready stream with m_last every BURST_LEN beats.
// Define FIFO_RD_STREAM_STATS_EN to add the xfer_count / stall_count statistics ports.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BURST_LEN  = 8,
  parameter int BEAT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow_err,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  proto_err
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           xfer_count,
  output logic [31:0]           stall_count
`endif
);

  rd_state_t             state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  proto_err_q, proto_err_d;
  logic [1:0]            occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  has_room_s;
  logic                  xfer_s;
  logic                  push_s;

  assign has_room_s = ({1'b0, occ_s} + {2'b00, inflight_q}) < 3'(RD_BUF_DEPTH);
  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && has_room_s;
  assign m_valid    = (occ_s != 2'd0);
  assign m_data     = head_s;
  assign m_last     = m_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign xfer_s     = m_valid && m_ready && !flush;
  // A word landing in the flush cycle or the FLUSH state belongs to the discarded stream.
  assign push_s     = inflight_q && !flush && (state_q != FLUSH);
  assign busy       = (state_q != IDLE) || (occ_s != 2'd0) || inflight_q;
  assign proto_err  = proto_err_q;

  rd_skid_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush),
    .push_i      (push_s),
    .push_data_i (fifo_rd_data),
    .pop_i       (xfer_s),
    .occ_o       (occ_s),
    .head_o      (head_s)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    state_d = enable ? RUN : IDLE;
        RUN:     state_d = enable ? RUN : DRAIN;
        DRAIN: begin
          if (enable) begin
            state_d = RUN;
          end else if ((occ_s == 2'd0) && !inflight_q) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    inflight_d  = fifo_rd_en;
    proto_err_d = proto_err_q | fifo_underflow_err |
                  (flush && (state_q == DRAIN) && (occ_s != 2'd0));
    if (flush) begin
      beat_d = '0;
    end else if (xfer_s) begin
      beat_d = m_last ? '0 : (beat_q + BEAT_W'(1));
    end else begin
      beat_d = beat_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      beat_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      beat_q      <= beat_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] xfer_cnt_q, stall_cnt_q;

  // Saturating statistics; deliberately untouched by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (xfer_s && (xfer_cnt_q != 32'hFFFF_FFFF)) begin
        xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
      if (m_valid && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign xfer_count  = xfer_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural registered-read FIFO.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, flush, fifo_empty, fifo_underflow_err, fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        m_valid, m_ready, m_last, busy, proto_err;
  logic [15:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] xfer_count, stall_count;
`endif

  fifo_rd_stream #(.DATA_WIDTH(16), .BURST_LEN(8), .BEAT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_underflow_err(fifo_underflow_err),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .proto_err(proto_err)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .xfer_count(xfer_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read, loaded on request.
  logic [15:0] fmem [64];
  int          fcount = 0;
  int          frptr  = 0;
  logic        ld_req = 1'b0;
  int          ld_n   = 0;
  logic [15:0] ld_base = 16'h0;

  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (ld_req) begin
      fcount <= ld_n;
      frptr  <= 0;
      for (int i = 0; i < 64; i++) fmem[i] <= ld_base + 16'(i);
    end else if (fifo_rd_en && fcount != 0) begin
      fifo_rd_data <= fmem[frptr];
      frptr        <= frptr + 1;
      fcount       <= fcount - 1;
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          tick_n = 0;
  int          stall_seen = 0;
  int          stab_viol = 0;
  int          rd_empty_viol = 0;
  logic [15:0] got_data[$];
  logic        got_last[$];
  int          got_tick[$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scores the current cycle, crosses one rising edge, then samples 1 ns after the falling edge.
  task automatic tick();
    logic        stall, fl, hold_last;
    logic [15:0] hold;
    tick_n++;
    if (m_valid && m_ready && !flush) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
      got_tick.push_back(tick_n);
    end
    if (m_valid && !m_ready) stall_seen++;
    if (fifo_rd_en && fifo_empty) rd_empty_viol++;
    stall = m_valid && !m_ready;
    fl = flush;
    hold = m_data;
    hold_last = m_last;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (stall && !fl && (!m_valid || m_data !== hold || m_last !== hold_last)) stab_viol++;
  endtask

  task automatic clr();
    got_data.delete();
    got_last.delete();
    got_tick.delete();
  endtask

  task automatic load(input int n, input logic [15:0] base);
    ld_n = n;
    ld_base = base;
    ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  task automatic collect(input int n, input int budget, input bit pattern);
    int ph = 0;
    while (got_data.size() < n && budget > 0) begin
      if (pattern) m_ready = (ph % 4 == 0) || (ph % 4 == 3);
      else         m_ready = 1'b1;
      ph++;
      budget--;
      tick();
    end
    check_vec("beats_rx", got_data.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    while (busy && budget > 0) begin
      budget--;
      tick();
    end
    check_vec("idle_reached", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
`ifdef FIFO_RD_STREAM_STATS_EN
    int x0, s0;
`endif
    rst = 1'b1; enable = 1'b0; flush = 1'b0; fifo_underflow_err = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    #1;
    check_vec("rst_rd_en", fifo_rd_en, 1'b0);
    check_vec("rst_valid", m_valid, 1'b0);
    check_vec("rst_data", m_data, 16'h0);
    check_vec("rst_last", m_last, 1'b0);
    check_vec("rst_busy", busy, 1'b0);
    check_vec("rst_perr", proto_err, 1'b0);
    rst = 1'b0;

    // Back-to-back streaming of 16 words.
    load(16, 16'h0001);
    clr();
    enable = 1'b1;
    m_ready = 1'b1;
    lat = 0;
    tick();
    while (!m_valid && lat < 10) begin
      lat++;
      tick();
    end
    check_vec("start_latency", lat, 2);
    collect(16, 100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check_vec("t1_data", got_data[i], 16'(i + 1));
      check_vec("t1_last", got_last[i], (i == 7 || i == 15));
    end
    check_vec("t1_b2b", got_tick[15] - got_tick[0], 15);
`ifdef FIFO_RD_STREAM_STATS_EN
    check_vec("t1_xfer_cnt", xfer_count, 32'd16);
`endif
    enable = 1'b0;
    wait_idle(20);

    // Backpressure pattern 1,0,0,1.
    load(16, 16'h0001);
    clr();
    stall_seen = 0;
`ifdef FIFO_RD_STREAM_STATS_EN
    x0 = xfer_count;
    s0 = stall_count;
`endif
    enable = 1'b1;
    collect(16, 200, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check_vec("t2_data", got_data[i], 16'(i + 1));
      check_vec("t2_last", got_last[i], (i == 7 || i == 15));
    end
    check_vec("t2_stall_hold", stab_viol, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check_vec("t2_stall_cnt", stall_count - s0, stall_seen);
    check_vec("t2_xfer_cnt", xfer_count - x0, 32'd16);
`endif
    enable = 1'b0;
    m_ready = 1'b1;
    wait_idle(20);

    // Drop enable after five transfers: three more words drain out.
    load(64, 16'h0100);
    clr();
    enable = 1'b1;
    collect(5, 50, 1'b0);
    enable = 1'b0;
    tick();
    check_vec("t3_drain_state", 32'(dut.state_q), 32'(DRAIN));
    wait_idle(20);
    check_vec("t3_idle_state", 32'(dut.state_q), 32'(IDLE));
    check_vec("t3_delivered", got_data.size(), 8);
    check_vec("t3_fifo_left", fcount, 56);
    for (int i = 0; i < 8; i++) check_vec("t3_data", got_data[i], 16'h0100 + 16'(i));
    check_vec("t3_last", got_last[7], 1'b1);

    // Flush with a full buffer in RUN, beat counter mid-frame.
    load(16, 16'h0200);
    clr();
    enable = 1'b1;
    collect(1, 20, 1'b0);
    m_ready = 1'b0;
    tick();
    tick();
    check_vec("t4_full_valid", m_valid, 1'b1);
    check_vec("t4_full_no_rd", fifo_rd_en, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_vec("t4_flush_valid", m_valid, 1'b0);
    check_vec("t4_flush_perr", proto_err, 1'b0);
    clr();
    collect(8, 60, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_vec("t4_data", got_data[i], 16'h0204 + 16'(i));
      check_vec("t4_last", got_last[i], (i == 7));
    end
    check_vec("t4_perr_after", proto_err, 1'b0);

    // Flush while draining with words buffered raises proto_err.
    enable = 1'b0;
    m_ready = 1'b0;
    tick();
    check_vec("t4_drain_state", 32'(dut.state_q), 32'(DRAIN));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_vec("t4_drain_flush_perr", proto_err, 1'b1);
    check_vec("t4_drain_flush_valid", m_valid, 1'b0);
    do_reset();
    check_vec("t5_perr_cleared", proto_err, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check_vec("t5_xfer_cnt_rst", xfer_count, 32'd0);
`endif

    // Underflow error is sticky through flush.
    tick();
    fifo_underflow_err = 1'b1;
    tick();
    fifo_underflow_err = 1'b0;
    check_vec("t5_uflow_perr", proto_err, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check_vec("t5_perr_sticky", proto_err, 1'b1);
    do_reset();
    check_vec("t5_perr_rst", proto_err, 1'b0);

    // Asynchronous reset in the middle of a burst.
    load(16, 16'h0300);
    m_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_vec("t6_pre_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("t6_valid", m_valid, 1'b0);
    check_vec("t6_data", m_data, 16'h0);
    check_vec("t6_last", m_last, 1'b0);
    check_vec("t6_busy", busy, 1'b0);
    check_vec("t6_rd_en", fifo_rd_en, 1'b0);
    check_vec("t6_perr", proto_err, 1'b0);
    enable = 1'b0;
    #1;
    rst = 1'b0;
    tick();

    check_vec("rd_en_while_empty", rd_empty_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
